// File: rtl/name_table_pkg.sv
// Shared encodings and default widths for the name table
// and the name hash unit that feeds it.
package name_table_pkg;

   localparam int DEF_HASH_W = 10;
   localparam int DEF_NAME_W = 64;
   localparam int DEF_LEN_W  = 6;
   localparam int DEF_PORT_W = 3;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'b00,
      OP_INSERT = 2'b01,
      OP_DELETE = 2'b10,
      OP_RSVD   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_OK    = 2'b00,
      ST_MISS  = 2'b01,
      ST_COLL  = 2'b10,
      ST_BADOP = 2'b11
   } status_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CMP,
      S_RESP
   } state_e;

endpackage

// File: rtl/name_table_ram.sv
// Single-port entry store: synchronous read, one-cycle latency,
// read-first on a write cycle.
module name_table_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 73
) (
   input  logic              clk,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/name_table.sv
// Direct-mapped name table: lookup/insert/delete of {name, len, port}
// with one request in flight and a held response.
module name_table
   import name_table_pkg::*;
#(
   parameter int HASH_W = DEF_HASH_W,
   parameter int NAME_W = DEF_NAME_W,
   parameter int LEN_W  = DEF_LEN_W,
   parameter int PORT_W = DEF_PORT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [HASH_W-1:0] req_hash,
   input  logic [NAME_W-1:0] req_name,
   input  logic [LEN_W-1:0]  req_len,
   input  logic [PORT_W-1:0] req_port,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_hit,
   output logic [PORT_W-1:0] rsp_port,
   output logic [1:0]        rsp_status,
   output logic [HASH_W:0]   occupancy
);

   localparam int DEPTH = 2**HASH_W;
   localparam int ENT_W = NAME_W + LEN_W + PORT_W;

   state_e            state;
   op_e               op_q;
   logic [HASH_W-1:0] hash_q;
   logic [NAME_W-1:0] name_q;
   logic [LEN_W-1:0]  len_q;
   logic [PORT_W-1:0] port_q;
   logic [DEPTH-1:0]  valid;

   logic              accept;
   logic              ram_en;
   logic              ram_we;
   logic [HASH_W-1:0] ram_addr;
   logic [ENT_W-1:0]  ram_wdata;
   logic [ENT_W-1:0]  ram_rdata;
   logic [NAME_W-1:0] st_name;
   logic [LEN_W-1:0]  st_len;
   logic [PORT_W-1:0] st_port;
   logic              occ;
   logic              match;

   assign req_ready = (state == S_IDLE);
   assign accept    = req_ready && req_valid;

   assign st_name = ram_rdata[ENT_W-1 -: NAME_W];
   assign st_len  = ram_rdata[PORT_W +: LEN_W];
   assign st_port = ram_rdata[PORT_W-1:0];

   assign occ   = valid[hash_q];
   assign match = occ && (st_name == name_q) && (st_len == len_q);

   // Reserved ops never touch the RAM; writes only land on the CMP edge.
   assign ram_we = !rst && (state == S_CMP) && (op_q == OP_INSERT)
                   && (!occ || match);
   assign ram_en = (accept && (op_e'(req_op) != OP_RSVD)) || ram_we;
   assign ram_addr  = req_ready ? req_hash : hash_q;
   assign ram_wdata = {name_q, len_q, port_q};

   name_table_ram #(
      .ADDR_W (HASH_W),
      .DATA_W (ENT_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         valid      <= '0;
         occupancy  <= '0;
         rsp_valid  <= 1'b0;
         rsp_hit    <= 1'b0;
         rsp_port   <= '0;
         rsp_status <= ST_OK;
         op_q       <= OP_LOOKUP;
         hash_q     <= '0;
         name_q     <= '0;
         len_q      <= '0;
         port_q     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (req_valid) begin
                  op_q   <= op_e'(req_op);
                  hash_q <= req_hash;
                  name_q <= req_name;
                  len_q  <= req_len;
                  port_q <= req_port;
                  state  <= S_READ;
               end
            end
            S_READ: begin
               state <= S_CMP;
            end
            S_CMP: begin
               state      <= S_RESP;
               rsp_valid  <= 1'b1;
               rsp_hit    <= 1'b0;
               rsp_port   <= '0;
               rsp_status <= ST_MISS;
               unique case (op_q)
                  OP_LOOKUP: begin
                     if (match) begin
                        rsp_hit    <= 1'b1;
                        rsp_port   <= st_port;
                        rsp_status <= ST_OK;
                     end
                  end
                  OP_INSERT: begin
                     if (match) begin
                        rsp_hit    <= 1'b1;
                        rsp_port   <= port_q;
                        rsp_status <= ST_OK;
                     end else if (!occ) begin
                        valid[hash_q] <= 1'b1;
                        occupancy     <= occupancy + 1'b1;
                        rsp_status    <= ST_OK;
                     end else begin
                        rsp_status <= ST_COLL;
                     end
                  end
                  OP_DELETE: begin
                     if (match) begin
                        valid[hash_q] <= 1'b0;
                        occupancy     <= occupancy - 1'b1;
                        rsp_hit       <= 1'b1;
                        rsp_port      <= st_port;
                        rsp_status    <= ST_OK;
                     end
                  end
                  OP_RSVD: begin
                     rsp_status <= ST_BADOP;
                  end
               endcase
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
         endcase
      end
   end

endmodule
